// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word via ready/ld and
// shifts it out one bit per enabled clock, with gapless back-to-back reloads.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  output logic             ready,
  output logic             sout,
  output logic             sout_vld,
  output logic             sout_last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] shreg_r, shreg_nx_s, shifted_s;
  logic [CW-1:0]    cnt_r, cnt_nx_s, cnt_inc_s;
  logic             sout_nx_s, vld_nx_s, last_nx_s;

  // Bit that goes on the wire first for a given register image.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Register image after the current head bit has retired.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  // Ready covers both idle and the edge on which the last bit retires.
  always_comb begin
    ready = 1'b0;
    if (rst) begin
      ready = 1'b0;
    end else if (state_r == IDLE) begin
      ready = 1'b1;
    end else if (sout_last_and_en()) begin
      ready = 1'b1;
    end else begin
      ready = 1'b0;
    end
  end

  function automatic logic sout_last_and_en();
    return sout_last & en;
  endfunction

  assign shifted_s = shift_once(shreg_r);
  assign cnt_inc_s = cnt_r + CW'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_nx_s = state_r;
    shreg_nx_s = shreg_r;
    cnt_nx_s   = cnt_r;
    sout_nx_s  = sout;
    vld_nx_s   = sout_vld;
    last_nx_s  = sout_last;
    if (ld && ready) begin
      state_nx_s = SHIFT;
      shreg_nx_s = in;
      cnt_nx_s   = CW'(0);
      sout_nx_s  = head_bit(in);
      vld_nx_s   = 1'b1;
      last_nx_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nx_s = IDLE;
        end
        SHIFT: begin
          if (!en) begin
            state_nx_s = SHIFT;
          end else if (sout_last) begin
            state_nx_s = IDLE;
            sout_nx_s  = 1'b0;
            vld_nx_s   = 1'b0;
            last_nx_s  = 1'b0;
          end else begin
            shreg_nx_s = shifted_s;
            cnt_nx_s   = cnt_inc_s;
            sout_nx_s  = head_bit(shifted_s);
            last_nx_s  = (cnt_inc_s == CW'(WIDTH - 1));
          end
        end
        default: begin
          state_nx_s = IDLE;
          sout_nx_s  = 1'b0;
          vld_nx_s   = 1'b0;
          last_nx_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset wins over any load or shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      shreg_r   <= '0;
      cnt_r     <= CW'(0);
      sout      <= 1'b0;
      sout_vld  <= 1'b0;
      sout_last <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      shreg_r   <= shreg_nx_s;
      cnt_r     <= cnt_nx_s;
      sout      <= sout_nx_s;
      sout_vld  <= vld_nx_s;
      sout_last <= last_nx_s;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a queue-of-pending-bits reference model.
module tb_piso_tx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ld = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] din = '0;

  logic ready_m, sout_m, vld_m, last_m;
  logic ready_l, sout_l, vld_l, last_l;

  int total = 0;
  int bad   = 0;

  bit q_m[$];
  bit q_l[$];

  piso_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .ld(ld), .in(din), .en(en),
    .ready(ready_m), .sout(sout_m), .sout_vld(vld_m), .sout_last(last_m)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .ld(ld), .in(din), .en(en),
    .ready(ready_l), .sout(sout_l), .sout_vld(vld_l), .sout_last(last_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive, check against model, then advance model across the edge.
  task automatic step(input logic r, input logic l, input logic e, input logic [W-1:0] d);
    logic rdy_m, rdy_l;
    @(negedge clk);
    rst = r; ld = l; en = e; din = d;
    #1;
    rdy_m = !r && (q_m.size() == 0 || (q_m.size() == 1 && e));
    rdy_l = !r && (q_l.size() == 0 || (q_l.size() == 1 && e));
    chk("ready_msb", ready_m, rdy_m);
    chk("vld_msb",   vld_m,   q_m.size() != 0);
    chk("sout_msb",  sout_m,  (q_m.size() != 0) ? q_m[0] : 1'b0);
    chk("last_msb",  last_m,  q_m.size() == 1);
    chk("ready_lsb", ready_l, rdy_l);
    chk("vld_lsb",   vld_l,   q_l.size() != 0);
    chk("sout_lsb",  sout_l,  (q_l.size() != 0) ? q_l[0] : 1'b0);
    chk("last_lsb",  last_l,  q_l.size() == 1);
    @(posedge clk);
    if (r) begin
      q_m.delete();
      q_l.delete();
    end else begin
      if (l && rdy_m) begin
        q_m.delete();
        for (int i = W - 1; i >= 0; i--) q_m.push_back(d[i]);
      end else if (e && q_m.size() != 0) begin
        void'(q_m.pop_front());
      end
      if (l && rdy_l) begin
        q_l.delete();
        for (int i = 0; i < W; i++) q_l.push_back(d[i]);
      end else if (e && q_l.size() != 0) begin
        void'(q_l.pop_front());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    // Reset held with load/shift requests present.
    step(1'b1, 1'b1, 1'b1, 4'hF);
    step(1'b1, 1'b1, 1'b1, 4'hF);
    // Single word, both orders, then an idle cycle.
    step(1'b0, 1'b1, 1'b1, 4'b1001);
    repeat (5) step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'b0011);
    repeat (5) step(1'b0, 1'b0, 1'b1, 4'h0);
    // Stall on the first bit.
    step(1'b0, 1'b1, 1'b1, 4'b1001);
    repeat (2) step(1'b0, 1'b0, 1'b0, 4'h0);
    repeat (5) step(1'b0, 1'b0, 1'b1, 4'h0);
    // Busy load ignored, then gapless reload on the last bit.
    step(1'b0, 1'b1, 1'b1, 4'b1001);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'b1111);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'b0110);
    repeat (5) step(1'b0, 1'b0, 1'b1, 4'h0);
    // Reset mid-word, then a clean word.
    step(1'b0, 1'b1, 1'b1, 4'b1001);
    repeat (2) step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b1, 1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'b0101);
    repeat (5) step(1'b0, 1'b0, 1'b1, 4'h0);
    // Randomized traffic with occasional resets and stalls.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0), W'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter. It loads a WIDTH-bit word through a ready/ld handshake and shifts it out one bit per enabled clock.
- It is the serialising counterpart of the team's parallel-load registers. It feeds a serial link or a downstream SIPO receiver.
- Supports gapless back-to-back words and a shift-enable input for rate control.

Parameters:
- WIDTH, 4, bits per word; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 sends in[WIDTH-1] first; 0 sends in[0] first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- ld  input  1  load request; the word is accepted on a rising edge where ld=1 and ready=1.
- in  input  WIDTH  parallel word; sampled only on an accepting edge.
- en  input  1  shift enable; the current bit advances only on edges with en=1.
- ready  output  1  combinational; transmitter can accept a word this cycle.
- sout  output  1  serial data, registered.
- sout_vld  output  1  sout carries a valid bit, registered.
- sout_last  output  1  sout is the final bit of the word, registered.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, shreg=0, cnt=0.
  - sout=0, sout_vld=0, sout_last=0.
  - rst has priority over ld and en.
  - Reset mid-word aborts the word with no partial completion; outputs take reset values on that edge.
- States:
  - IDLE: no word in flight.
  - SHIFT: a word is being sent.
- ready:
  - 1 in IDLE.
  - 1 in SHIFT only when sout_last=1 and en=1 (the last bit is retiring this edge).
  - 0 otherwise.
  - ready is 0 while rst=1.
- Accepting edge (ld=1, ready=1):
  - shreg<=in; state<=SHIFT; cnt<=0.
  - sout<=first bit (per MSB_FIRST); sout_vld<=1.
  - sout_last<=0, because WIDTH >= 2.
  - Latency: the first bit is valid in the cycle immediately after the accepting edge.
- SHIFT, edge with en=1 and sout_last=0:
  - Advance to the next bit; cnt<=cnt+1.
  - sout_last<=1 when the new cnt = WIDTH-1.
- SHIFT, edge with en=0:
  - All state and outputs hold.
  - Each bit is presented for 1 + (number of en=0 edges) cycles.
- SHIFT, edge with en=1 and sout_last=1:
  - If ld=1: treat as an accepting edge. The new word's first bit follows with no gap, and sout_vld stays 1.
  - Else: state<=IDLE; sout_vld<=0; sout_last<=0; sout<=0.
- ld while ready=0: ignored and not queued; in is not sampled.
- en while IDLE: no effect.
- sout is forced to 0 whenever sout_vld=0.
- cnt width is clog2(WIDTH), minimum 1. cnt never exceeds WIDTH-1 and never wraps mid-word.
- Word duration with en held at 1: exactly WIDTH cycles of sout_vld=1.

Test Plan:
- Reset: rst=1 for 2 edges with ld=1, in=4'hF, en=1 -> ready=1, sout_vld=0, sout=0, sout_last=0; no word starts.
- MSB-first single word: WIDTH=4, in=4'b1001, ld pulse, en=1 -> sout=1,0,0,1 on 4 consecutive cycles; sout_last=1 only on the 4th; cycle 5 shows sout_vld=0, ready=1.
- LSB-first: MSB_FIRST=0, in=4'b0011, en=1 -> sout=1,1,0,0; sout_last on the 4th bit.
- Stall: in=4'b1001, en=0 for 2 edges after the first bit -> first bit '1' held 3 cycles; word lasts 6 cycles; bit order unchanged.
- Back-to-back and busy-ignore:
  - Load 4'b1001.
  - Assert ld with in=4'b1111 during bit 2 -> ignored.
  - Assert ld with in=4'b0110 during the last bit -> sout=1,0,0,1,0,1,1,0 with sout_vld continuous for 8 cycles; sout_last on cycles 4 and 8.
- Reset mid-word: load 4'b1001, rst=1 after 2 bits -> next cycle sout_vld=0, ready=1. A subsequent load of 4'b0101 transmits 0,1,0,1 cleanly.
